// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
// Segment patterns are active-low, bit order gfedcba.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit scan controller with blanking and
// frame-synchronous double-buffered loads.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV_VALUE    = 2499,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int PW = (DIV_VALUE > 0) ? $clog2(DIV_VALUE + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV_VALUE);
    localparam logic [7:0]    BLK_LAST = 8'(BLANK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    blk_q, blk_d;

    logic [15:0]   sh_val_q, sh_val_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_bl_q, sh_bl_d;
    logic [15:0]   pd_val_q, pd_val_d;
    logic [3:0]    pd_dp_q, pd_dp_d;
    logic [3:0]    pd_bl_q, pd_bl_d;
    logic          pend_q, pend_d;

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ack_q, ack_d;
    logic          tick_q, tick_d;

    logic [3:0]    nib_d;
    logic [6:0]    dec_d;

    seg7_hex_decode u_dec (
        .nibble (nib_d),
        .seg_n  (dec_d)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pre_d    = pre_q;
        blk_d    = blk_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_bl_d  = sh_bl_q;
        pd_val_d = pd_val_q;
        pd_dp_d  = pd_dp_q;
        pd_bl_d  = pd_bl_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        tick_d   = 1'b0;

        unique case (state_q)
            SHOW: begin
                if (pre_q == PRE_LAST) begin
                    state_d = BLANK;
                    idx_d   = idx_q + 2'd1;
                    blk_d   = '0;
                    if (idx_q == 2'd3) begin
                        tick_d = 1'b1;
                        if (pend_q) begin
                            sh_val_d = pd_val_q;
                            sh_dp_d  = pd_dp_q;
                            sh_bl_d  = pd_bl_q;
                            ack_d    = 1'b1;
                            pend_d   = 1'b0;
                        end
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            BLANK: begin
                if (blk_q == BLK_LAST) begin
                    state_d = SHOW;
                    pre_d   = '0;
                end else begin
                    blk_d = blk_q + 8'd1;
                end
            end
            default: state_d = BLANK;
        endcase

        // A load on the commit edge lands in pending after the old copy moved.
        if (load) begin
            pd_val_d = value_in;
            pd_dp_d  = dp_in;
            pd_bl_d  = blank_in;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        unique case (idx_d)
            2'd0:    nib_d = sh_val_d[3:0];
            2'd1:    nib_d = sh_val_d[7:4];
            2'd2:    nib_d = sh_val_d[11:8];
            default: nib_d = sh_val_d[15:12];
        endcase
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == SHOW) begin
            seg_d = dec_d;
            dp_d  = ~sh_dp_d[idx_d];
            if (!sh_bl_d[idx_d]) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BLANK;
            idx_q    <= '0;
            pre_q    <= '0;
            blk_q    <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_bl_q  <= '0;
            pd_val_q <= '0;
            pd_dp_q  <= '0;
            pd_bl_q  <= '0;
            pend_q   <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            ack_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            blk_q    <= blk_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_bl_q  <= sh_bl_d;
            pd_val_q <= pd_val_d;
            pd_dp_q  <= pd_dp_d;
            pd_bl_q  <= pd_bl_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            ack_q    <= ack_d;
            tick_q   <= tick_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign load_ack   = ack_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized and directed bench for seg7_scan_ctrl against a
// cycle-position reference model.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 3;
    localparam int BLK   = 2;
    localparam int SLOT  = DIV + 1 + BLK;
    localparam int FRAME = 4 * SLOT;
    localparam logic [13:0] ALL_OFF = {4'hF, 7'h7F, 1'b1, 2'b00};

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(
        .DIV_VALUE    (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .load_ack   (load_ack),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk_in = ~clk_in;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference: n = rising edges since reset release.
    int          n;
    logic        m_pending;
    logic        m_ack;
    logic [15:0] pv_val, m_val;
    logic [3:0]  pv_dp, m_dp, pv_bl, m_bl;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            n         <= 0;
            m_pending <= 1'b0;
            m_ack     <= 1'b0;
            pv_val    <= '0;
            pv_dp     <= '0;
            pv_bl     <= '0;
            m_val     <= '0;
            m_dp      <= '0;
            m_bl      <= '0;
        end else begin
            n     <= n + 1;
            m_ack <= (((n + 1) % FRAME) == 0) && m_pending;
            if ((((n + 1) % FRAME) == 0) && m_pending) begin
                m_val <= pv_val;
                m_dp  <= pv_dp;
                m_bl  <= pv_bl;
            end
            if (load) begin
                pv_val    <= value_in;
                pv_dp     <= dp_in;
                pv_bl     <= blank_in;
                m_pending <= 1'b1;
            end else if (((n + 1) % FRAME) == 0) begin
                m_pending <= 1'b0;
            end
        end
    end

    int          dig;
    logic        show;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_tick;
    logic [13:0] exp_v;
    logic [13:0] dut_v;

    always_comb begin
        dig      = (n / SLOT) % 4;
        show     = (n > 0) && ((n % SLOT) >= BLK);
        exp_an   = 4'hF;
        exp_seg  = 7'h7F;
        exp_dp   = 1'b1;
        exp_tick = (n > 0) && ((n % FRAME) == 0);
        if (show) begin
            exp_seg = seg_tab[m_val[dig*4 +: 4]];
            exp_dp  = ~m_dp[dig];
            if (!m_bl[dig]) exp_an = ~(4'b0001 << dig);
        end
        exp_v = {exp_an, exp_seg, exp_dp, m_ack, exp_tick};
    end

    assign dut_v = {an_n, seg_n, dp_n, load_ack, frame_tick};

    task automatic test_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        blank_in = '0;
        repeat (3) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== ALL_OFF) begin
                errors++;
                $display("FAIL reset_hold got %h exp %h", dut_v, ALL_OFF);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL reset_run n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            if (n == 2) begin
                checks++;
                if ({an_n, seg_n} !== {4'hE, 7'h40}) begin
                    errors++;
                    $display("FAIL first_digit got %h/%h exp e/40",
                             an_n, seg_n);
                end
            end
            if (n == 8) begin
                checks++;
                if (an_n !== 4'hD) begin
                    errors++;
                    $display("FAIL second_digit got %h exp d", an_n);
                end
            end
            if (n == 23 || n == 24) begin
                checks++;
                if (frame_tick !== (n == 24)) begin
                    errors++;
                    $display("FAIL first_tick n=%0d got %b", n, frame_tick);
                end
            end
        end
    endtask

    task automatic test_load_mid();
        int stage = 0;
        logic [10:0] want [4];
        want[0] = {4'hE, 7'h19};
        want[1] = {4'hD, 7'h30};
        want[2] = {4'hB, 7'h24};
        want[3] = {4'h7, 7'h79};
        for (int c = 0; c < 120 && stage < 6; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL load_mid n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            load = 1'b0;
            if (stage == 0 && (n % FRAME) == 9) begin
                value_in = 16'h1234;
                dp_in    = 4'h0;
                blank_in = 4'h0;
                load     = 1'b1;
                stage    = 1;
            end else if (stage == 1 && load_ack) begin
                checks++;
                if (!frame_tick || (n % FRAME) != 0) begin
                    errors++;
                    $display("FAIL ack_tick n=%0d got %b exp 1",
                             n, frame_tick);
                end
                stage = 2;
            end else if (stage >= 2 && (n % SLOT) == BLK) begin
                checks++;
                if ({an_n, seg_n} !== want[stage-2]) begin
                    errors++;
                    $display("FAIL new_digit d=%0d got %h exp %h",
                             stage - 2, {an_n, seg_n}, want[stage-2]);
                end
                stage++;
            end
        end
        checks++;
        if (stage != 6) begin
            errors++;
            $display("FAIL load_mid_timeout got %0d exp 6", stage);
        end
    endtask

    task automatic test_three_loads();
        int acks = 0;
        int stage = 0;
        for (int c = 0; c < 120 && stage < 5; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL three n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            load = 1'b0;
            if (stage >= 1 && load_ack) acks++;
            if (stage == 0 && (n % FRAME) == 3) begin
                value_in = 16'h1111;
                load     = 1'b1;
                stage    = 1;
            end else if (stage == 1 && (n % FRAME) == 8) begin
                value_in = 16'h2222;
                load     = 1'b1;
                stage    = 2;
            end else if (stage == 2 && (n % FRAME) == 13) begin
                value_in = 16'h3333;
                load     = 1'b1;
                stage    = 3;
            end else if (stage == 3 && (n % FRAME) == BLK) begin
                checks++;
                if (seg_n !== 7'h30) begin
                    errors++;
                    $display("FAIL latest_wins got %h exp 30", seg_n);
                end
                stage = 4;
            end else if (stage == 4 && (n % FRAME) == 20) begin
                stage = 5;
            end
        end
        checks++;
        if (acks != 1 || stage != 5) begin
            errors++;
            $display("FAIL single_ack got %0d exp 1 (stage %0d)",
                     acks, stage);
        end
    endtask

    task automatic test_coincident();
        int stage = 0;
        for (int c = 0; c < 120 && stage < 6; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL coincident n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            load = 1'b0;
            if (stage == 0 && (n % FRAME) == 10) begin
                value_in = 16'hAAAA;
                load     = 1'b1;
                stage    = 1;
            end else if (stage == 1 && (n % FRAME) == FRAME - 1) begin
                value_in = 16'h5555;
                load     = 1'b1;
                stage    = 2;
            end else if (stage == 2) begin
                checks++;
                if (!load_ack) begin
                    errors++;
                    $display("FAIL coin_ack1 got %b exp 1", load_ack);
                end
                stage = 3;
            end else if (stage == 3 && (n % FRAME) == BLK) begin
                checks++;
                if (seg_n !== 7'h08) begin
                    errors++;
                    $display("FAIL coin_old got %h exp 08", seg_n);
                end
                stage = 4;
            end else if (stage == 4 && (n % FRAME) == 0) begin
                checks++;
                if (!load_ack) begin
                    errors++;
                    $display("FAIL coin_ack2 got %b exp 1", load_ack);
                end
                stage = 5;
            end else if (stage == 5 && (n % FRAME) == BLK) begin
                checks++;
                if (seg_n !== 7'h12) begin
                    errors++;
                    $display("FAIL coin_new got %h exp 12", seg_n);
                end
                stage = 6;
            end
        end
        checks++;
        if (stage != 6) begin
            errors++;
            $display("FAIL coin_timeout got %0d exp 6", stage);
        end
    endtask

    task automatic test_blank_dp();
        int stage = 0;
        int bad   = 0;
        int lit   = 0;
        for (int c = 0; c < 120 && stage < 3; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL blank_dp n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            load = 1'b0;
            if (stage == 2) begin
                if (!dp_n) lit++;
                if (!dp_n && an_n != 4'hD) bad++;
                if (an_n == 4'hE || an_n == 4'hB) bad++;
                if ((n % FRAME) == FRAME - 1) stage = 3;
            end
            if (stage == 0 && (n % FRAME) == 5) begin
                value_in = 16'($urandom);
                dp_in    = 4'b0010;
                blank_in = 4'b0101;
                load     = 1'b1;
                stage    = 1;
            end else if (stage == 1 && load_ack) begin
                stage = 2;
            end
        end
        checks++;
        if (bad != 0 || lit != DIV + 1 || stage != 3) begin
            errors++;
            $display("FAIL blank_dp_sum got bad=%0d lit=%0d exp 0/%0d",
                     bad, lit, DIV + 1);
        end
        dp_in    = '0;
        blank_in = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL random n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            load     = ($urandom_range(0, 3) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks  = 0;
        int stage = 0;
        for (int c = 0; c < 60 && stage < 2; c++) begin
            @(negedge clk_in);
            load = 1'b0;
            if (stage == 0 && (n % FRAME) == 4) begin
                value_in = 16'h9876;
                dp_in    = 4'hF;
                blank_in = 4'h0;
                load     = 1'b1;
                stage    = 1;
            end else if (stage == 1 && (n % SLOT) == BLK + 1) begin
                stage = 2;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== ALL_OFF || stage != 2) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", dut_v, ALL_OFF);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset n=%0d got %h exp %h",
                         n, dut_v, exp_v);
            end
            if (load_ack) acks++;
            if (n == BLK) begin
                checks++;
                if ({an_n, seg_n, dp_n} !== {4'hE, 7'h40, 1'b1}) begin
                    errors++;
                    $display("FAIL shadow_cleared got %h exp e401",
                             {an_n, seg_n, dp_n});
                end
            end
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL dropped_ack got %0d exp 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_load_mid();
        test_three_loads();
        test_coincident();
        test_blank_dp();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_VALUE, default 2499, giving the SHOW dwell of DIV_VALUE+1 clk_in cycles per digit.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, giving the inter-digit blanking dwell in clk_in cycles; legal range is 1..255.
REQ-003 clk_in  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 value_in  input  16  four hex nibbles; nibble k drives digit k, with digit 0 = bits [3:0].
REQ-006 dp_in  input  4  decimal point per digit, 1 = lit.
REQ-007 blank_in  input  4  per-digit blank, 1 = digit dark.
REQ-008 load  input  1  single-cycle request to capture value_in, dp_in and blank_in.
REQ-009 load_ack  output  1  one-cycle pulse when captured data is committed to the display.
REQ-010 an_n  output  4  active-low digit anodes.
REQ-011 seg_n  output  7  active-low segments, bit order gfedcba.
REQ-012 dp_n  output  1  active-low decimal point.
REQ-013 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 The FSM SHALL have two states, SHOW and BLANK, and SHALL hold a 2-bit digit index idx.
REQ-015 SHOW behaviour:
- prescaler counts 0..DIV_VALUE.
- at DIV_VALUE the FSM goes to BLANK and idx increments, wrapping 3->0.
- prescaler clears on every entry to SHOW.
REQ-016 BLANK behaviour:
- blank counter counts 0..BLANK_CYCLES-1, then the FSM goes to SHOW.
- an_n=4'hF, seg_n=7'h7F and dp_n=1 throughout BLANK.
REQ-017 SHOW outputs:
- an_n has only bit idx low; seg_n is the hex decode of shadow nibble idx; dp_n = ~shadow_dp[idx].
- if shadow_blank[idx]=1, an_n=4'hF instead.
REQ-018 All outputs SHALL be registered and driven from next-state logic, so they change on the same edge as the state register, with no extra latency.
REQ-019 Hex decode (seg_n):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-020 Load capture: load=1 SHALL capture the inputs into a pending register and set the pending flag on the same edge; a later load before commit overwrites the pending data, latest wins.
REQ-021 Frame boundary: the SHOW->BLANK transition with idx==3 is the frame boundary; frame_tick pulses on that edge.
REQ-022 Commit: if pending=1 at the frame boundary, pending data SHALL copy to the shadow registers, load_ack SHALL pulse, and pending SHALL clear, so digit 0 of the next frame shows the new data.
REQ-023 Simultaneous load and frame boundary: the commit uses the pending contents from before that edge, the new load is captured into pending, pending stays 1, and it is acked at the next boundary.
REQ-024 load_ack SHALL be issued at most once per frame, regardless of how many loads occurred.

Reset
REQ-025 While rst_n=0 the block SHALL hold: state=BLANK, idx=0, both counters=0, shadow and pending registers=0, pending flag=0, an_n=4'hF, seg_n=7'h7F, dp_n=1, load_ack=0, frame_tick=0.
REQ-026 Assertion of rst_n mid-frame SHALL take effect immediately and asynchronously, dropping any pending load without ack.
REQ-027 After rst_n deasserts, the first displayed digit SHALL be digit 0, after BLANK_CYCLES cycles.

Structure
REQ-028 Shared package seg7_pkg SHALL hold:
- the state encoding constants SHOW and BLANK
- the 16-entry segment table
- SEG_OFF=7'h7F and AN_OFF=4'hF
REQ-029 The hex decode SHALL be one combinational sub-module, seg7_hex_decode, which takes a 4-bit nibble and returns 7-bit seg_n; all sequencing stays in seg7_scan_ctrl.

Verification
REQ-030 The bench SHALL run with DIV_VALUE=3 and BLANK_CYCLES=2, so a digit slot is 6 cycles and a frame is 24 cycles.
REQ-031 The bench SHALL cover the following directed scenarios:
- Reset release, no load -> 2 cycles all off, then an_n=E with seg_n=40 for 4 cycles, then 2 cycles all off, then an_n=D; frame_tick first pulses 24 cycles after release.
- load with value_in=16'h1234 mid-frame -> digits keep old data until the boundary; load_ack and frame_tick pulse together; the next frame shows digit0 seg_n=19, digit1 30, digit2 24, digit3 79.
- Three loads in one frame (1111, 2222, 3333) -> a single load_ack, and 3333 is displayed.
- load coincident with the frame_tick edge -> the prior pending data commits now; the new data is acked and displayed one frame later.
- blank_in=4'b0101 and dp_in=4'b0010 -> an_n stays F during digit 0 and 2 slots; dp_n=0 only while an_n=D.
- rst_n asserted mid-SHOW with a pending load -> outputs go off immediately, no load_ack, and the shadow reads 0 (seg_n=40) after restart.
